reg_rename_file: RTL
====================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file plus register-status (rename) table; producer side of the RS/LSB issue operand interface.
//  Per issued instruction, resolves rs1/rs2 into {V,Q,R}: value ready (R=1, V valid) or pending on ROB tag (R=0, Q valid).
//  Forwarding sources: ALU/LSB CDB broadcast, ROB-held result, same-cycle commit. Committed results written from ROB.
//  Rollback clears all renames.
// PARAMETERS
//  XLEN      32  data width
//  NREG      32  architectural registers (x0 hardwired zero)
//  TAG_W     4   ROB tag width (equals width of `ROBRange)
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, synchronous, active-high
//  rdy              in   1      global enable; state frozen when low
//  rs1, rs2         in   5      source register indices of instruction being issued
//  issue_valid      in   1      instruction issues this cycle
//  issue_rd         in   5      destination register of issuing instruction
//  issue_tag        in   TAG_W  ROB tag allocated to issuing instruction
//  Vj, Vk           out  XLEN   operand values (valid when Rj/Rk=1)
//  Qj, Qk           out  TAG_W  producer tags (valid when Rj/Rk=0)
//  Rj, Rk           out  1      operand ready
//  rob_q1, rob_q2   out  TAG_W  ROB lookup tags (= tag[rs1], tag[rs2])
//  rob_rdy1, rob_rdy2 in 1      ROB entry at rob_qN has result
//  rob_val1, rob_val2 in XLEN   that result
//  B_ALU_valid/_result/_rdTag   in 1/XLEN/TAG_W  ALU CDB
//  B_LSB_valid/_result/_rdTag   in 1/XLEN/TAG_W  LSB CDB
//  commit_valid     in   1      ROB commits a register write
//  commit_rd        in   5      committed destination
//  commit_tag       in   TAG_W  committing ROB tag
//  commit_value     in   XLEN   committed value
//  rollback         in   1      flush speculative state
// BEHAVIOUR
//  State: regs[NREG], busy[NREG], tag[NREG]. Reset: all regs=0, busy=0, tag=0.
//  Operand read (combinational, same cycle, from pre-update state), per source s with index r:
//   r==0 or !busy[r]           -> R=1, V=regs[r], Q=0
//   else T=tag[r], first match in order:
//     B_ALU_valid & rdTag==T   -> R=1, V=B_ALU_result
//     B_LSB_valid & rdTag==T   -> R=1, V=B_LSB_result
//     rob_rdyN                 -> R=1, V=rob_valN
//     commit_valid & commit_tag==T -> R=1, V=commit_value
//     otherwise                -> R=0, Q=T, V=0
//  Same-instruction hazard: issue_rd==rs1 reads old mapping (addi x1,x1,1 depends on previous x1 producer).
//  Sequential update at posedge clk, only when rdy & !rst, in this order (later wins):
//   1. commit_valid & commit_rd!=0: regs[rd]<=commit_value;
//      if busy[rd] & tag[rd]==commit_tag: busy[rd]<=0 (younger rename kept otherwise).
//   2. issue_valid & issue_rd!=0 & !rollback: busy[rd]<=1, tag[rd]<=issue_tag (overrides step 1 clear on same rd).
//   3. rollback: busy<=all 0; commit write of step 1 still performed; issue ignored.
//  x0: never written, never busy; reads always R=1, V=0.
//  rdy=0: no state change; combinational outputs still driven.
//  Reset mid-operation: wins over rdy, commit, issue, rollback.
//  No internal latency: operand outputs valid the cycle inputs are; RS latches them at next edge.
// STRUCTURE
//  defines.v: `ROBRange, `True/`False, REG_CNT, XLEN constants; no new typedefs.
//  Sub-module operand_resolve (pure combinational, instantiated twice for j/k): busy/tag/regs lookup + forwarding priority.
//  Top: state arrays, update always block, ROB lookup port wiring.
// TESTING
//  Reset, read rs1=5,rs2=0 -> Rj=Rk=1, Vj=0, Vk=0.
//  Issue rd=3 tag=2; next cycle rs1=3, no forwards -> Rj=0, Qj=2; B_ALU_valid tag=2 result=0x55 same cycle -> Rj=1, Vj=0x55.
//  x3 busy tag=2, rob_rdy1=1 rob_val1=0x77 -> Rj=1, Vj=0x77; commit rd=3 tag=2 val=0x77 -> regs[3]=0x77, busy[3]=0.
//  x3 busy tag=2, same cycle commit rd=3 tag=2 and issue rd=3 tag=6 -> busy[3]=1, tag[3]=6, regs[3]=commit value.
//  Commit rd=4 tag=1 while tag[4]=5 -> regs[4] updated, busy[4] stays 1, tag[4]=5.
//  Rollback with issue rd=7 and commit rd=8 val=0x9 -> all busy=0, regs[8]=0x9, tag[7] unchanged; issue/commit rd=0 -> x0 stays 0.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// reg_rename_file_pkg: shared widths for the register file / rename table slice
package reg_rename_file_pkg;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int TAG_W = 4;
   localparam int RW    = $clog2(NREG);
endpackage

// File: rtl/reg_rename_file_operand_resolve.sv
// reg_rename_file_operand_resolve: resolves one source register into {V,Q,R}
// using the rename table and CDB / ROB / commit forwarding, in priority order.
module reg_rename_file_operand_resolve
   import reg_rename_file_pkg::*;
(
   input  logic [RW-1:0]    i_idx,
   input  logic [XLEN-1:0]  i_regs [NREG],
   input  logic [NREG-1:0]  i_busy,
   input  logic [TAG_W-1:0] i_tag [NREG],
   input  logic             i_rob_rdy,
   input  logic [XLEN-1:0]  i_rob_val,
   input  logic             i_alu_valid,
   input  logic [XLEN-1:0]  i_alu_result,
   input  logic [TAG_W-1:0] i_alu_tag,
   input  logic             i_lsb_valid,
   input  logic [XLEN-1:0]  i_lsb_result,
   input  logic [TAG_W-1:0] i_lsb_tag,
   input  logic             i_commit_valid,
   input  logic [TAG_W-1:0] i_commit_tag,
   input  logic [XLEN-1:0]  i_commit_value,
   output logic [XLEN-1:0]  o_v,
   output logic [TAG_W-1:0] o_q,
   output logic             o_r,
   output logic [TAG_W-1:0] o_tag
);
   logic [TAG_W-1:0] w_t;

   assign w_t   = i_tag[i_idx];
   assign o_tag = w_t;

   always_comb begin
      o_r = 1'b1;
      o_v = '0;
      o_q = '0;
      if (i_idx == '0 || !i_busy[i_idx]) o_v = i_regs[i_idx];
      else if (i_alu_valid && i_alu_tag == w_t) o_v = i_alu_result;
      else if (i_lsb_valid && i_lsb_tag == w_t) o_v = i_lsb_result;
      else if (i_rob_rdy) o_v = i_rob_val;
      else if (i_commit_valid && i_commit_tag == w_t) o_v = i_commit_value;
      else begin
         o_r = 1'b0;
         o_q = w_t;
      end
   end
endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file plus rename table; supplies
// issue operands with forwarding, takes commits from the ROB, flushes on rollback.
module reg_rename_file
   import reg_rename_file_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_rdy,
   input  logic [RW-1:0]    i_rs1,
   input  logic [RW-1:0]    i_rs2,
   input  logic             i_issue_valid,
   input  logic [RW-1:0]    i_issue_rd,
   input  logic [TAG_W-1:0] i_issue_tag,
   output logic [XLEN-1:0]  o_vj,
   output logic [XLEN-1:0]  o_vk,
   output logic [TAG_W-1:0] o_qj,
   output logic [TAG_W-1:0] o_qk,
   output logic             o_rj,
   output logic             o_rk,
   output logic [TAG_W-1:0] o_rob_q1,
   output logic [TAG_W-1:0] o_rob_q2,
   input  logic             i_rob_rdy1,
   input  logic             i_rob_rdy2,
   input  logic [XLEN-1:0]  i_rob_val1,
   input  logic [XLEN-1:0]  i_rob_val2,
   input  logic             i_b_alu_valid,
   input  logic [XLEN-1:0]  i_b_alu_result,
   input  logic [TAG_W-1:0] i_b_alu_rd_tag,
   input  logic             i_b_lsb_valid,
   input  logic [XLEN-1:0]  i_b_lsb_result,
   input  logic [TAG_W-1:0] i_b_lsb_rd_tag,
   input  logic             i_commit_valid,
   input  logic [RW-1:0]    i_commit_rd,
   input  logic [TAG_W-1:0] i_commit_tag,
   input  logic [XLEN-1:0]  i_commit_value,
   input  logic             i_rollback
);
   logic [XLEN-1:0]  r_regs [NREG];
   logic [NREG-1:0]  r_busy;
   logic [TAG_W-1:0] r_tag  [NREG];

   reg_rename_file_operand_resolve u_res_j (
      .i_idx(i_rs1), .i_regs(r_regs), .i_busy(r_busy), .i_tag(r_tag),
      .i_rob_rdy(i_rob_rdy1), .i_rob_val(i_rob_val1),
      .i_alu_valid(i_b_alu_valid), .i_alu_result(i_b_alu_result), .i_alu_tag(i_b_alu_rd_tag),
      .i_lsb_valid(i_b_lsb_valid), .i_lsb_result(i_b_lsb_result), .i_lsb_tag(i_b_lsb_rd_tag),
      .i_commit_valid(i_commit_valid), .i_commit_tag(i_commit_tag), .i_commit_value(i_commit_value),
      .o_v(o_vj), .o_q(o_qj), .o_r(o_rj), .o_tag(o_rob_q1)
   );

   reg_rename_file_operand_resolve u_res_k (
      .i_idx(i_rs2), .i_regs(r_regs), .i_busy(r_busy), .i_tag(r_tag),
      .i_rob_rdy(i_rob_rdy2), .i_rob_val(i_rob_val2),
      .i_alu_valid(i_b_alu_valid), .i_alu_result(i_b_alu_result), .i_alu_tag(i_b_alu_rd_tag),
      .i_lsb_valid(i_b_lsb_valid), .i_lsb_result(i_b_lsb_result), .i_lsb_tag(i_b_lsb_rd_tag),
      .i_commit_valid(i_commit_valid), .i_commit_tag(i_commit_tag), .i_commit_value(i_commit_value),
      .o_v(o_vk), .o_q(o_qk), .o_r(o_rk), .o_tag(o_rob_q2)
   );

   // Statement order matters: a same-cycle issue rename overrides the commit
   // clear, and rollback overrides every busy bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
            r_tag[i]  <= '0;
         end
         r_busy <= '0;
      end else if (i_rdy) begin
         if (i_commit_valid && i_commit_rd != '0) begin
            r_regs[i_commit_rd] <= i_commit_value;
            if (r_busy[i_commit_rd] && r_tag[i_commit_rd] == i_commit_tag) r_busy[i_commit_rd] <= 1'b0;
         end
         if (i_issue_valid && i_issue_rd != '0 && !i_rollback) begin
            r_busy[i_issue_rd] <= 1'b1;
            r_tag[i_issue_rd]  <= i_issue_tag;
         end
         if (i_rollback) r_busy <= '0;
      end
   end
endmodule
